// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB
// operand forwarding and one-cycle load-use stall detection.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs_addr,
    input  logic [RADDR-1:0] id_rt_addr,
    input  logic [RADDR-1:0] id_rd_addr,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic [4:0]       id_alu_op,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [4:0]       alu_op,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_illegal
);
    logic [RADDR-1:0] rs_addr, rt_addr;
    logic [XLEN-1:0]  rs_data, rt_data, imm, rs_fwd, rt_fwd;
    logic             use_imm, legal, bad;

    always_comb begin
        legal = (id_alu_op == 5'b00000) | (id_alu_op == 5'b00001) | (id_alu_op == 5'b00100)
              | (id_alu_op == 5'b00101) | (id_alu_op == 5'b00110);
        bad = id_valid & ~legal;
        id_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid
                 & ((ex_rd == id_rs_addr) | ((ex_rd == id_rt_addr) & (~id_use_imm | id_mem_write)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush || id_stall) begin
            ex_valid     <= 1'b0;
            rs_addr      <= '0;
            rt_addr      <= '0;
            ex_rd        <= '0;
            rs_data      <= '0;
            rt_data      <= '0;
            imm          <= '0;
            use_imm      <= 1'b0;
            alu_op       <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            rs_addr      <= id_rs_addr;
            rt_addr      <= id_rt_addr;
            ex_rd        <= id_rd_addr;
            rs_data      <= id_rs_data;
            rt_data      <= id_rt_data;
            imm          <= id_imm;
            use_imm      <= id_use_imm;
            alu_op       <= bad ? 5'b00000 : id_alu_op;
            ex_reg_write <= id_reg_write & ~bad;
            ex_mem_read  <= id_mem_read & ~bad;
            ex_mem_write <= id_mem_write & ~bad;
            ex_illegal   <= bad;
        end
    end

    // EX/MEM beats MEM/WB; r0 is never forwarded so bubbles stay at zero
    always_comb begin
        rs_fwd = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_addr) ? exmem_result :
                 (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_addr) ? memwb_result : rs_data;
        rt_fwd = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_addr) ? exmem_result :
                 (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_addr) ? memwb_result : rt_data;
        alu_a = rs_fwd;
        ex_store_data = rt_fwd;
        alu_b = use_imm ? imm : rt_fwd;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan scenarios plus randomized traffic checked
// against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write, flush;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_op, ex_rd;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .id_stall(id_stall), .ex_valid(ex_valid), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // model of what the EX stage holds
    logic        m_v, m_ui, m_rw, m_mr, m_mw, m_ill;
    logic [4:0]  m_rs, m_rt, m_rd, m_op;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  legal_ops [5] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6};

    task automatic mreset();
        {m_v, m_ui, m_rw, m_mr, m_mw, m_ill} = '0;
        {m_rs, m_rt, m_rd, m_op} = '0;
        {m_rsd, m_rtd, m_imm} = '0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == a) return memwb_result;
        return d;
    endfunction

    function automatic bit exp_stall();
        bit need_rt = !id_use_imm || id_mem_write;
        return m_v && m_mr && m_rd != 0 && id_valid &&
               (m_rd == id_rs_addr || (need_rt && m_rd == id_rt_addr));
    endfunction

    task automatic step(output bit st);
        bit legal;
        logic [31:0] es;
        #1;
        st = exp_stall();
        es = fwd(m_rt, m_rtd);
        check("stall", id_stall, st);
        check("alu_a", alu_a, fwd(m_rs, m_rsd));
        check("alu_b", alu_b, m_ui ? m_imm : es);
        check("store", ex_store_data, es);
        check("op", alu_op, m_op);
        check("rd", ex_rd, m_rd);
        check("flags", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
              {m_v, m_rw, m_mr, m_mw, m_ill});
        @(posedge clk);
        legal = 0;
        foreach (legal_ops[k]) if (legal_ops[k] == id_alu_op) legal = 1;
        if (flush || st) mreset();
        else begin
            m_v = id_valid; m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
            m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_ui = id_use_imm;
            m_ill = id_valid && !legal;
            m_op = m_ill ? 5'd0 : id_alu_op;
            m_rw = id_reg_write && !m_ill;
            m_mr = id_mem_read && !m_ill;
            m_mw = id_mem_write && !m_ill;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                          input logic ui, input logic [4:0] op, input logic rw, mr, mw);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
        id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                           input logic mw, input logic [4:0] mr, input logic [31:0] mv);
        exmem_reg_write = ew; exmem_rd = er; exmem_result = ev;
        memwb_reg_write = mw; memwb_rd = mr; memwb_result = mv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st, prev;
        int k;
        flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        mreset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_a", alu_a, 0);
        @(negedge clk);
        reset_n = 1;
        set_id(1, 1, 2, 3, 5, 7, 0, 0, 5'd0, 1, 0, 0);
        step(st);
        check("add_a", alu_a, 5);
        check("add_b", alu_b, 7);
        check("add_op", alu_op, 0);
        check("add_rd", ex_rd, 3);
        check("add_rw", ex_reg_write, 1);
        set_id(1, 1, 2, 4, 99, 3, 0, 0, 5'd1, 1, 0, 0);
        set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
        step(st);
        check("fwd_a", alu_a, 32'h10);
        check("fwd_b", alu_b, 3);
        check("fwd_op", alu_op, 1);
        set_id(1, 0, 2, 4, 0, 3, 0, 0, 5'd0, 1, 0, 0);
        set_fwd(1, 0, 32'h55, 1, 0, 32'h66);
        step(st);
        check("r0_a", alu_a, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 2, 5, 0, 0, 8, 1, 5'd0, 1, 1, 0);
        step(st);
        set_id(1, 5, 7, 6, 0, 9, 0, 0, 5'd6, 1, 0, 0);
        #1 check("lu_stall", id_stall, 1);
        step(st);
        check("lu_bub_v", ex_valid, 0);
        check("lu_bub_rw", ex_reg_write, 0);
        check("lu_stall_off", id_stall, 0);
        set_fwd(0, 0, 0, 1, 5, 32'hAB);
        step(st);
        check("lu_a", alu_a, 32'hAB);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 2, 5, 0, 0, 8, 1, 5'd0, 1, 1, 0);
        step(st);
        set_id(1, 5, 7, 6, 0, 9, 0, 0, 5'd6, 1, 0, 0);
        flush = 1;
        #1 check("fl_stall", id_stall, 1);
        step(st);
        check("fl_mr", ex_mem_read, 0);
        check("fl_v", ex_valid, 0);
        set_id(1, 1, 2, 3, 5, 7, 0, 0, 5'd0, 1, 0, 0);
        step(st);
        check("fl_norm_v", ex_valid, 0);
        flush = 0;
        set_id(1, 1, 2, 3, 5, 7, 32'hFFFFFFFC, 1, 5'd0, 1, 0, 0);
        step(st);
        check("imm_b", alu_b, 32'hFFFFFFFC);
        set_id(1, 1, 2, 3, 5, 7, 0, 0, 5'd7, 1, 0, 0);
        step(st);
        check("ill_op", alu_op, 0);
        check("ill_flag", ex_illegal, 1);
        check("ill_rw", ex_reg_write, 0);
        prev = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset_n = 0;
                #1;
                check("arst_valid", ex_valid, 0);
                check("arst_op", alu_op, 0);
                check("arst_a", alu_a, 0);
                check("arst_b", alu_b, 0);
                mreset();
                @(negedge clk);
                reset_n = 1;
                prev = 0;
            end
            if (!prev) begin
                k = $urandom_range(0, 3);
                set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 4)],
                       1'($urandom_range(0, 1)), k == 0, k == 1);
            end
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            flush = $urandom_range(0, 7) == 0;
            step(st);
            prev = st;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
